pdm_capture_sequencer: RTL and testbench

Control block sitting between the APU register interface and the PDM front-end converter. It latches a capture configuration, enables and clocks the converter, discards a programmable number of microphone warm-up samples, then packs the converter's one-bit-per-event stream into per-channel words. Words are delivered on a valid/ready interface to the decimation filter or sample FIFO, with overrun detection.

---
 rtl/pdm_capture_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pdm_capture_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_sequencer.sv
// pdm_capture_sequencer: latches capture config, runs the PDM converter,
// discards warm-up samples, packs bits into per-channel words (valid/ready).
// Ports: clk_i/rst_n_i (async active-low), start_i/stop_i control,
//   dual_channel_i/channel_i/clock_divisor_i/warmup_i config,
//   conv_* converter controls, pdm_data_i/pdm_valid_i/pdm_channel_i stream,
//   word_o/word_channel_o/word_valid_o/word_ready_i output, busy_o, overrun_o.
// Option macro: PDM_SEQ_OVERRUN_HALT_EN -- an overrun halts capture (to DRAIN).
module pdm_capture_sequencer #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  dual_channel_i,
    input  logic                  channel_i,
    input  logic [6:0]            clock_divisor_i,
    input  logic [15:0]           warmup_i,
    output logic                  conv_clk_en_o,
    output logic                  conv_dual_channel_o,
    output logic                  conv_channel_o,
    output logic [6:0]            conv_clock_divisor_o,
    input  logic                  pdm_data_i,
    input  logic                  pdm_valid_i,
    input  logic                  pdm_channel_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_channel_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [15:0]                 warmup_q;
    logic [15:0]                 warm_cnt_q;
    logic [1:0][WORD_WIDTH-1:0]  sr_q;
    logic [1:0][CW-1:0]          bit_cnt_q;

    logic                  accept;
    logic                  out_free;
    logic                  shift;
    logic                  load;
    logic                  set_ovf;
    logic                  start_cap;
    logic [WORD_WIDTH-1:0] new_word;

    // Events for the non-selected channel are ignored in single mode.
    assign accept   = pdm_valid_i &&
                      (conv_dual_channel_o || (pdm_channel_i == conv_channel_o));
    // Output slot can take a word if empty or being drained this cycle.
    assign out_free = !word_valid_o || word_ready_i;
    assign new_word = {sr_q[pdm_channel_i][WORD_WIDTH-2:0], pdm_data_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift     = 1'b0;
        load      = 1'b0;
        set_ovf   = 1'b0;
        start_cap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_cap = 1'b1;
                    state_d   = WARMUP;
                end
            end
            WARMUP: begin
                if (stop_i) begin
                    state_d = DRAIN;
                end else if (warm_cnt_q == warmup_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // stop takes priority; a word completing now is dropped silently
                if (stop_i) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    shift = 1'b1;
                    if (bit_cnt_q[pdm_channel_i] == LAST) begin
                        if (out_free) begin
                            load = 1'b1;
                        end else begin
                            set_ovf = 1'b1;
`ifdef PDM_SEQ_OVERRUN_HALT_EN
                            state_d = DRAIN;
`else
                            state_d = CAPTURE;
`endif
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            conv_clk_en_o        <= 1'b0;
            conv_dual_channel_o  <= 1'b0;
            conv_channel_o       <= 1'b0;
            conv_clock_divisor_o <= '0;
            warmup_q             <= '0;
            warm_cnt_q           <= '0;
            sr_q                 <= '0;
            bit_cnt_q            <= '0;
            word_o               <= '0;
            word_channel_o       <= 1'b0;
            word_valid_o         <= 1'b0;
            busy_o               <= 1'b0;
            overrun_o            <= 1'b0;
        end else begin
            // Status outputs follow the next state so they are registered.
            conv_clk_en_o <= (state_d == WARMUP) || (state_d == CAPTURE);
            busy_o        <= (state_d != IDLE);

            if (start_cap) begin
                conv_dual_channel_o  <= dual_channel_i;
                conv_channel_o       <= channel_i;
                conv_clock_divisor_o <= clock_divisor_i;
                warmup_q             <= warmup_i;
                warm_cnt_q           <= '0;
                sr_q                 <= '0;
                bit_cnt_q            <= '0;
                overrun_o            <= 1'b0;
            end

            if (state_q == WARMUP && pdm_valid_i) begin
                warm_cnt_q <= warm_cnt_q + 16'd1;
            end

            // Counter width is log2(WORD_WIDTH), so it wraps to 0 on completion.
            if (shift) begin
                sr_q[pdm_channel_i]      <= new_word;
                bit_cnt_q[pdm_channel_i] <= bit_cnt_q[pdm_channel_i] + CW'(1);
            end

            if (load) begin
                word_o         <= new_word;
                word_channel_o <= pdm_channel_i;
                word_valid_o   <= 1'b1;
            end else if (word_ready_i) begin
                word_valid_o <= 1'b0;
            end

            if (set_ovf) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// Testbench for pdm_capture_sequencer: directed stimulus, scoreboard queue
// of expected words, independent monitor comparing on each transfer.
module tb_pdm_capture_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         dual;
    logic         chan;
    logic [6:0]   div;
    logic [15:0]  warm;
    logic         conv_en;
    logic         conv_dual;
    logic         conv_chan;
    logic [6:0]   conv_div;
    logic         pdm_data;
    logic         pdm_valid;
    logic         pdm_chan;
    logic [W-1:0] word;
    logic         word_ch;
    logic         word_valid;
    logic         word_ready;
    logic         busy;
    logic         overrun;

    int vectors = 0;
    int errors  = 0;
    logic [W:0] exp_q[$];

    pdm_capture_sequencer #(.WORD_WIDTH(W)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .start_i             (start),
        .stop_i              (stop),
        .dual_channel_i      (dual),
        .channel_i           (chan),
        .clock_divisor_i     (div),
        .warmup_i            (warm),
        .conv_clk_en_o       (conv_en),
        .conv_dual_channel_o (conv_dual),
        .conv_channel_o      (conv_chan),
        .conv_clock_divisor_o(conv_div),
        .pdm_data_i          (pdm_data),
        .pdm_valid_i         (pdm_valid),
        .pdm_channel_i       (pdm_chan),
        .word_o              (word),
        .word_channel_o      (word_ch),
        .word_valid_o        (word_valid),
        .word_ready_i        (word_ready),
        .busy_o              (busy),
        .overrun_o           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got ch=%0d word=%h, none expected",
                         word_ch, word);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({word_ch, word} !== e) begin
                    errors++;
                    $display("FAIL word: got ch=%0d word=%h, expected ch=%0d word=%h",
                             word_ch, word, e[W], e[W-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic d, input logic c, input logic [6:0] dv,
                            input logic [15:0] wu, input logic with_stop);
        dual  = d;
        chan  = c;
        div   = dv;
        warm  = wu;
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send_bit(input logic c, input logic b);
        pdm_valid = 1'b1;
        pdm_chan  = c;
        pdm_data  = b;
        tick();
        pdm_valid = 1'b0;
    endtask

    task automatic send_word(input logic c, input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(c, w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        dual       = 1'b0;
        chan       = 1'b0;
        div        = '0;
        warm       = '0;
        pdm_data   = 1'b0;
        pdm_valid  = 1'b0;
        pdm_chan   = 1'b0;
        word_ready = 1'b1;
        idle(2);
        check("reset_outputs",
              {conv_en, conv_dual, conv_chan, conv_div, word, word_ch,
               word_valid, busy, overrun},
              32'h0);
        rst_n = 1'b1;
        idle(1);

        // Warm-up discard
        do_start(1'b0, 1'b0, 7'd12, 16'd4, 1'b0);
        check("start_clk_en", conv_en, 1);
        check("start_busy", busy, 1);
        check("start_divisor", conv_div, 7'd12);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        idle(2);
        exp_q.push_back({1'b0, 16'hA5C3});
        send_word(1'b0, 16'hA5C3);
        idle(3);
        check("warmup_overrun", overrun, 0);
        do_stop();
        idle(2);

        // Dual interleave
        do_start(1'b1, 1'b0, 7'd3, 16'd0, 1'b0);
        check("dual_latched", conv_dual, 1);
        idle(2);
        exp_q.push_back({1'b0, 16'hFFFF});
        exp_q.push_back({1'b1, 16'h0000});
        for (int i = 0; i < W; i++) begin
            send_bit(1'b0, 1'b1);
            send_bit(1'b1, 1'b0);
        end
        idle(3);
        do_stop();
        idle(2);

        // Backpressure, single RIGHT with LEFT noise ignored
        word_ready = 1'b0;
        do_start(1'b0, 1'b1, 7'd9, 16'd0, 1'b0);
        check("right_latched", conv_chan, 1);
        idle(2);
        exp_q.push_back({1'b1, 16'h1234});
        send_bit(1'b0, 1'b1);
        send_word(1'b1, 16'h1234);
        check("bp_first_valid", {word_valid, word}, {1'b1, 16'h1234});
        send_bit(1'b0, 1'b1);
        send_word(1'b1, 16'hBEEF);
        check("bp_overrun", overrun, 1);
        check("bp_word_stable", {word_valid, word_ch, word},
              {2'b11, 16'h1234});
`ifdef PDM_SEQ_OVERRUN_HALT_EN
        check("bp_clk_en", conv_en, 0);
`else
        check("bp_clk_en", conv_en, 1);
`endif
        word_ready = 1'b1;
        idle(2);
        do_stop();
        idle(2);
        check("bp_idle", busy, 0);

        // Stop mid-word
        do_start(1'b0, 1'b0, 7'd5, 16'd0, 1'b0);
        check("restart_clears_overrun", overrun, 0);
        idle(2);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
        do_stop();
        check("stop_clk_en", conv_en, 0);
        check("stop_busy_drain", busy, 1);
        tick();
        check("stop_busy_idle", busy, 0);
        idle(4);

        // Start and stop together; completion on an accept cycle
        word_ready = 1'b0;
        do_start(1'b0, 1'b0, 7'd7, 16'd0, 1'b1);
        check("startstop_busy", busy, 1);
        check("startstop_clk_en", conv_en, 1);
        idle(2);
        exp_q.push_back({1'b0, 16'h8001});
        exp_q.push_back({1'b0, 16'h7E3C});
        send_word(1'b0, 16'h8001);
        for (int i = W - 1; i >= 1; i--) send_bit(1'b0, 16'h7E3C >> i);
        word_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check("accept_load_valid", {word_valid, word}, {1'b1, 16'h7E3C});
        idle(2);
        check("accept_no_overrun", overrun, 0);
        do_stop();
        idle(2);

        // Asynchronous reset mid-capture with a word pending
        word_ready = 1'b0;
        do_start(1'b1, 1'b1, 7'h55, 16'd0, 1'b0);
        idle(2);
        send_word(1'b0, 16'hDEAD);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {conv_en, conv_dual, conv_chan, conv_div, word, word_ch,
               word_valid, busy, overrun},
              32'h0);
        tick();
        rst_n = 1'b1;
        word_ready = 1'b1;
        idle(1);
        do_start(1'b0, 1'b0, 7'd2, 16'd1, 1'b0);
        check("post_reset_busy", busy, 1);
        send_bit(1'b0, 1'b1);
        idle(2);
        exp_q.push_back({1'b0, 16'h0F0F});
        send_word(1'b0, 16'h0F0F);
        idle(3);
        do_stop();
        idle(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
